// File: rtl/fdivsqrt_pkg.sv
// Shared types and radix derivation for the divide/sqrt on-the-fly converter.
// Radix 4 is selected by defining FDIVSQRT_OTFC_RADIX4_EN; radix 2 otherwise.
package fdivsqrt_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef logic signed [2:0] digit_t;

`ifdef FDIVSQRT_OTFC_RADIX4_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  function automatic int iters_of(input int divb);
    return divb / L;
  endfunction

  // Digits beyond the radix's redundant set are illegal.
  function automatic logic digit_legal(input digit_t d);
`ifdef FDIVSQRT_OTFC_RADIX4_EN
    return (d >= -3'sd2) && (d <= 3'sd2);
`else
    return (d >= -3'sd1) && (d <= 3'sd1);
`endif
  endfunction

endpackage

// File: rtl/fdivsqrt_otfc_chk.sv
// Simulation checker: flags accepted digits outside the legal set for the radix
// selected by FDIVSQRT_OTFC_RADIX4_EN.
module fdivsqrt_otfc_chk
  import fdivsqrt_pkg::*;
(
  input logic   clk,
  input logic   reset_n,
  input logic   acc,
  input digit_t digit
);

  // Illegal digits are converted as zero by the datapath; report them here.
  always @(posedge clk) begin
    if (reset_n && acc) begin
      assert (digit_legal(digit)) else $error("illegal otfc digit %0d", digit);
    end
  end

endmodule

// File: rtl/fdivsqrt_otfc_step.sv
// Combinational single-digit update of U/UM for the on-the-fly converter.
// Radix follows FDIVSQRT_OTFC_RADIX4_EN through fdivsqrt_pkg::L.
module fdivsqrt_otfc_step
  import fdivsqrt_pkg::*;
#(
  parameter int DIVb = 64
) (
  input  logic [DIVb:0] u,
  input  logic [DIVb:0] um,
  input  logic [DIVb:0] k,
  input  digit_t        digit,
  output logic [DIVb:0] unext,
  output logic [DIVb:0] umnext
);

  digit_t          d_s;
  digit_t          dm1_s;
  logic [L-1:0]    fu_s;
  logic [L-1:0]    fum_s;
  logic [DIVb:0]   base_u_s;
  logic [DIVb:0]   base_um_s;

  // Low L bits of d and d-1 in two's complement equal d, r+d, d-1, r+d-1 mod r,
  // so only the base (U or UM) depends on the digit sign.
  always_comb begin
    d_s   = digit_legal(digit) ? digit : 3'sd0;
    dm1_s = d_s - 3'sd1;
    fu_s  = d_s[L-1:0];
    fum_s = dm1_s[L-1:0];
    if (d_s[2]) begin
      base_u_s  = um;
      base_um_s = um;
    end else if (d_s == 3'sd0) begin
      base_u_s  = u;
      base_um_s = um;
    end else begin
      base_u_s  = u;
      base_um_s = u;
    end
    unext  = base_u_s  | (k * {{(DIVb+1-L){1'b0}}, fu_s});
    umnext = base_um_s | (k * {{(DIVb+1-L){1'b0}}, fum_s});
  end

endmodule

// File: rtl/fdivsqrt_otfc_seq.sv
// Sequential on-the-fly converter: one signed digit per cycle into U/UM.
// Radix 4 when FDIVSQRT_OTFC_RADIX4_EN is defined, radix 2 otherwise.
module fdivsqrt_otfc_seq
  import fdivsqrt_pkg::*;
#(
  parameter int DIVb = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          sqrt,
  input  logic          flush,
  input  logic          digit_valid,
  input  digit_t        digit,
  output logic          digit_ready,
  output logic          busy,
  output logic          done,
  output logic [DIVb:0] U,
  output logic [DIVb:0] UM
);

  localparam int ITERS = iters_of(DIVb);
  localparam int CW    = $clog2(ITERS + 1);

  state_e          state_r, state_nxt_s;
  logic [DIVb:0]   u_r, um_r, k_r;
  logic [DIVb:0]   unext_s, umnext_s;
  logic [CW-1:0]   cnt_r;
  logic            done_r, done_nxt_s;
  logic            acc_s, load_s, step_s, clr_s;

  fdivsqrt_otfc_step #(.DIVb(DIVb)) u_step (
    .u      (u_r),
    .um     (um_r),
    .k      (k_r),
    .digit  (digit),
    .unext  (unext_s),
    .umnext (umnext_s)
  );

  fdivsqrt_otfc_chk u_chk (
    .clk     (clk),
    .reset_n (reset_n),
    .acc     (acc_s),
    .digit   (digit)
  );

  // Next-state and datapath controls; priority flush > start > digit.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    clr_s       = 1'b0;
    done_nxt_s  = 1'b0;
    acc_s       = (state_r == RUN) && digit_valid;
    case (state_r)
      IDLE: begin
        if (flush) begin
          clr_s = 1'b1;
        end else if (start) begin
          load_s      = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (flush) begin
          clr_s       = 1'b1;
          state_nxt_s = IDLE;
        end else if (start) begin
          load_s = 1'b1;
        end else if (acc_s) begin
          step_s = 1'b1;
          if (cnt_r == CW'(ITERS - 1)) begin
            state_nxt_s = IDLE;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state and completion pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Result registers, digit weight K and iteration counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      u_r   <= '0;
      um_r  <= '0;
      k_r   <= '0;
      cnt_r <= '0;
    end else if (load_s) begin
      u_r   <= sqrt ? {1'b1, {DIVb{1'b0}}} : {(DIVb+1){1'b0}};
      um_r  <= sqrt ? {(DIVb+1){1'b0}} : {1'b1, {DIVb{1'b0}}};
      k_r   <= {{DIVb{1'b0}}, 1'b1} << (DIVb - L);
      cnt_r <= '0;
    end else if (step_s) begin
      u_r   <= unext_s;
      um_r  <= umnext_s;
      k_r   <= k_r >> L;
      cnt_r <= cnt_r + CW'(1);
    end else if (clr_s) begin
      cnt_r <= '0;
    end
  end

  assign busy        = (state_r == RUN);
  assign digit_ready = busy;
  assign done        = done_r;
  assign U           = u_r;
  assign UM          = um_r;

endmodule

// File: tb/tb_fdivsqrt_otfc_seq.sv
// Directed self-checking bench for fdivsqrt_otfc_seq at DIVb = 8; radix-specific
// vectors follow FDIVSQRT_OTFC_RADIX4_EN.
module tb_fdivsqrt_otfc_seq;
  import fdivsqrt_pkg::*;

  localparam int DIVb = 8;
  localparam int NIT  = DIVb / L;

  logic        clk = 1'b0;
  logic        reset_n, start, sqrt, flush, digit_valid;
  digit_t      digit;
  logic        digit_ready, busy, done;
  logic [DIVb:0] U, UM;
  logic [15:0] k0;
  int          checks = 0;
  int          failures = 0;

  fdivsqrt_otfc_seq #(.DIVb(DIVb)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sqrt(sqrt), .flush(flush),
    .digit_valid(digit_valid), .digit(digit), .digit_ready(digit_ready),
    .busy(busy), .done(done), .U(U), .UM(UM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic begin_op(input logic sq);
    start = 1'b1;
    sqrt  = sq;
    @(negedge clk);
    start = 1'b0;
    sqrt  = 1'b0;
  endtask

  task automatic feed(input digit_t d);
    digit_valid = 1'b1;
    digit       = d;
    @(negedge clk);
    digit_valid = 1'b0;
    digit       = 3'sd0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; sqrt = 1'b0; flush = 1'b0;
    digit_valid = 1'b0; digit = 3'sd0;
    k0 = 16'h0001 << (DIVb - L);
    repeat (2) @(negedge clk);
    chk("rst_u", 16'(U), 16'h000);
    chk("rst_um", 16'(UM), 16'h000);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_ready", 16'(digit_ready), 16'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // digit_valid in IDLE is ignored
    digit_valid = 1'b1; digit = 3'sd1;
    @(negedge clk);
    digit_valid = 1'b0; digit = 3'sd0;
    chk("idle_digit_u", 16'(U), 16'h000);
    chk("idle_digit_busy", 16'(busy), 16'h0);

`ifdef FDIVSQRT_OTFC_RADIX4_EN
    begin_op(1'b0);
    chk("r4_busy", 16'(busy), 16'h1);
    feed(3'sd2); feed(-3'sd1); feed(3'sd0); feed(3'sd0);
    chk("r4_done", 16'(done), 16'h1);
    chk("r4_busy_end", 16'(busy), 16'h0);
    chk("r4_u", 16'(U), 16'h070);
    chk("r4_um", 16'(UM), 16'h06F);
    @(negedge clk);
    chk("r4_done_pulse", 16'(done), 16'h0);
`else
    begin_op(1'b0);
    chk("r2a_busy", 16'(busy), 16'h1);
    feed(3'sd1);
    for (int i = 0; i < 7; i++) begin
      chk("r2a_no_early_done", 16'(done), 16'h0);
      feed(3'sd0);
    end
    chk("r2a_done", 16'(done), 16'h1);
    chk("r2a_busy_end", 16'(busy), 16'h0);
    chk("r2a_u", 16'(U), 16'h080);
    chk("r2a_um", 16'(UM), 16'h07F);
    @(negedge clk);
    chk("r2a_done_pulse", 16'(done), 16'h0);

    begin_op(1'b0);
    feed(3'sd1); feed(-3'sd1);
    for (int i = 0; i < 6; i++) feed(3'sd0);
    chk("r2b_done", 16'(done), 16'h1);
    chk("r2b_u", 16'(U), 16'h040);
    chk("r2b_um", 16'(UM), 16'h03F);
    @(negedge clk);
    chk("r2b_done_pulse", 16'(done), 16'h0);

    begin_op(1'b1);
    chk("r2s_init_u", 16'(U), 16'h100);
    chk("r2s_init_um", 16'(UM), 16'h000);
    feed(-3'sd1);
    for (int i = 0; i < 7; i++) feed(3'sd0);
    chk("r2s_done", 16'(done), 16'h1);
    chk("r2s_u", 16'(U), 16'h080);
    chk("r2s_um", 16'(UM), 16'h07F);
    @(negedge clk);
`endif

    // gaps mid-operation hold state
    begin_op(1'b0);
    feed(3'sd1);
    digit = -3'sd1;
    repeat (3) @(negedge clk);
    digit = 3'sd0;
    chk("gap_u", 16'(U), k0);
    chk("gap_um", 16'(UM), 16'h000);
    chk("gap_busy", 16'(busy), 16'h1);
    for (int i = 1; i < NIT; i++) feed(3'sd0);
    chk("gap_done", 16'(done), 16'h1);
    chk("gap_u_final", 16'(U), k0);
    chk("gap_um_final", 16'(UM), k0 - 16'h1);

    // start in the done cycle: sqrt initial values loaded
    begin_op(1'b1);
    chk("b2b_busy", 16'(busy), 16'h1);
    chk("b2b_u", 16'(U), 16'h100);
    chk("b2b_um", 16'(UM), 16'h000);

    // restart in RUN with a digit present: digit discarded, counter restarts
    feed(3'sd1);
    start = 1'b1; digit_valid = 1'b1; digit = 3'sd1;
    @(negedge clk);
    start = 1'b0; digit_valid = 1'b0; digit = 3'sd0;
    chk("restart_u", 16'(U), 16'h000);
    chk("restart_um", 16'(UM), 16'h100);
    for (int i = 0; i < NIT - 1; i++) feed(3'sd0);
    chk("restart_no_done", 16'(done), 16'h0);
    feed(3'sd0);
    chk("restart_done", 16'(done), 16'h1);
    chk("restart_um_final", 16'(UM), 16'h1FF);

    // flush with start in RUN: IDLE, no load, no done
    begin_op(1'b0);
    feed(3'sd1);
    flush = 1'b1; start = 1'b1; sqrt = 1'b1; digit_valid = 1'b1; digit = 3'sd1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0; sqrt = 1'b0; digit_valid = 1'b0; digit = 3'sd0;
    chk("flush_busy", 16'(busy), 16'h0);
    chk("flush_u", 16'(U), k0);
    chk("flush_um", 16'(UM), 16'h000);
    for (int i = 0; i < NIT + 1; i++) begin
      chk("flush_no_done", 16'(done), 16'h0);
      feed(3'sd1);
    end
    chk("flush_u_hold", 16'(U), k0);

    // asynchronous reset mid-RUN
    begin_op(1'b1);
    feed(-3'sd1);
    feed(3'sd0);
    digit_valid = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_u", 16'(U), 16'h000);
    chk("arst_um", 16'(UM), 16'h000);
    chk("arst_busy", 16'(busy), 16'h0);
    chk("arst_done", 16'(done), 16'h0);
    @(negedge clk);
    digit_valid = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < NIT + 1; i++) begin
      @(negedge clk);
      chk("arst_no_done", 16'(done), 16'h0);
    end
    chk("arst_idle", 16'(busy), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
